smooth_frame_ctrl: RTL and testbench
====================================

SMOOTH_FRAME_CTRL -- requirements
Module: smooth_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 1024, pixels per line.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 768, lines per frame.
REQ-003 SHALL have parameter VALUE_BITS, default 9, pixel width.
REQ-004 SHALL have parameters KERNEL_WIDTH and KERNEL_HEIGHT, each default 3, odd, at least 3.
REQ-005 SHALL have parameter CALC_LATENCY, default 2, enabled cycles from window output to the smoother's registered output.
REQ-006 SHALL have ports: clk in 1, single clock; rst in 1, asynchronous active-high reset.
REQ-007 SHALL have ports: start in 1, frame start pulse; busy out 1, frame in progress; frame_done out 1, one-cycle end pulse.
REQ-008 SHALL have ports: in_valid in 1; in_data in VALUE_BITS; in_ready out 1.
REQ-009 SHALL have ports: win_en out 1, drives smoother en; win_data out VALUE_BITS, drives smoother value_in.
REQ-010 SHALL have ports: out_valid out 1, smoother output register holds a result; out_ready in 1, consumer accept.
REQ-011 SHALL have ports: out_x out $clog2(FRAME_WIDTH); out_y out $clog2(FRAME_HEIGHT); out_border out 1.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> FLUSH -> DONE -> IDLE.
REQ-013 SHALL define N = FRAME_WIDTH*FRAME_HEIGHT.
REQ-014 SHALL define L = FRAME_WIDTH*(KERNEL_HEIGHT/2) + KERNEL_WIDTH/2 + CALC_LATENCY, using integer division.
REQ-015 IDLE: start moves the FSM to RUN next cycle and clears all counters; in IDLE, in_ready=0, win_en=0, busy=0.
REQ-016 SHALL define stall = out_valid && !out_ready.
REQ-017 RUN: in_ready = !stall; win_en = in_valid && !stall; win_data = in_data.
REQ-018 RUN: after the N-th accepted pixel, the FSM SHALL enter FLUSH next cycle.
REQ-019 FLUSH: in_ready=0; win_en = !stall; win_data = 0.
REQ-020 FLUSH: after L enabled cycles, the FSM SHALL enter DONE.
REQ-021 DONE: frame_done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 SHALL keep an enable counter en_cnt, cleared at start and incremented on each win_en, of width $clog2(N+L+1).
REQ-023 On a win_en cycle, out_valid SHALL be registered as (en_cnt >= L), where en_cnt is the pre-increment value.
REQ-024 On a non-win_en cycle, out_valid SHALL clear when out_ready=1 and hold when out_ready=0.
REQ-025 Exactly N out_valid&&out_ready transfers SHALL occur per frame.
REQ-026 out_x/out_y SHALL give the coordinate of the current output, start at 0,0, and advance on each out_valid&&out_ready.
REQ-027 out_x SHALL wrap at FRAME_WIDTH-1 and increment out_y.
REQ-028 out_border SHALL be combinational: out_x < KERNEL_WIDTH/2, out_x >= FRAME_WIDTH-KERNEL_WIDTH/2, out_y < KERNEL_HEIGHT/2, or out_y >= FRAME_HEIGHT-KERNEL_HEIGHT/2.
REQ-029 busy SHALL be 1 in RUN, FLUSH and DONE.
REQ-030 start while busy SHALL be ignored.
REQ-031 start in the DONE cycle SHALL be ignored.
REQ-032 in_valid outside RUN SHALL be ignored and not acknowledged.
REQ-033 out_ready low SHALL freeze en_cnt, the FSM counters and the smoother (win_en=0); no data is lost or duplicated.

Reset
REQ-034 On rst, asynchronously: FSM=IDLE; busy, frame_done, in_ready, win_en, out_valid = 0; win_data, out_x, out_y, en_cnt and the input counter = 0.
REQ-035 Reset mid-frame SHALL abandon the frame; the first frame after reset SHALL behave as a clean frame from start.

Structure
REQ-036 Package smooth_ctrl_pkg SHALL hold the state enum type and a latency function computing L from the parameters.
REQ-037 One sub-module, xy_counter (parameterised width/height, inc input, x/y/last outputs, async reset), SHALL be instantiated for input pixel counting and for output coordinates.
REQ-038 The block SHALL contain no smoother datapath; it drives an external spatial smoothing instance.

Verification (W=8, H=4, KW=KH=3, CALC_LATENCY=2 -> L=11, N=32)
REQ-039 Start plus a continuous input stream with out_ready=1 SHALL produce: win_en high for 43 cycles; first out_valid after the 12th enable; 32 outputs; frame_done 1 cycle after FLUSH ends.
REQ-040 Border check: outputs (0,0), (7,3) and (3,0) SHALL have out_border=1; (3,1) and (6,2) SHALL have out_border=0.
REQ-041 Backpressure: out_ready=0 for 5 cycles mid-frame SHALL keep win_en=0, in_ready=0 and out_valid/out_x held; the output sequence SHALL be identical to the unstalled run.
REQ-042 Random in_valid gaps (50%) SHALL still give exactly 32 outputs in raster order; win_en SHALL never be high while in_valid=0 in RUN.
REQ-043 start pulses in RUN and DONE SHALL be ignored: no counter reset and exactly one frame_done.
REQ-044 rst asserted at pixel 20 SHALL drive all outputs to reset values immediately; a following start SHALL yield a complete correct 32-output frame.

Source files
------------

// File: rtl/smooth_ctrl_pkg.sv
// Shared types and helpers for the smoothing frame controller.
package smooth_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } ctrl_state_e;

    // Enabled cycles from the first pixel in to the first valid smoother result.
    function automatic int unsigned calc_latency(input int unsigned frame_width,
                                                 input int unsigned kernel_width,
                                                 input int unsigned kernel_height,
                                                 input int unsigned calc_lat);
        return frame_width * (kernel_height / 2) + kernel_width / 2 + calc_lat;
    endfunction

endpackage

// File: rtl/xy_counter.sv
// Raster-order x/y position counter with wrap and last-position flag.
module xy_counter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic                      last
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clr) begin
            x_q <= '0;
            y_q <= '0;
        end else if (inc) begin
            if (x_q == X_MAX) begin
                x_q <= '0;
                y_q <= (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/smooth_frame_ctrl.sv
// Frame sequencer for an external spatial smoother: feeds pixels, flushes the
// window pipeline, and tracks output validity and coordinates.
module smooth_frame_ctrl
    import smooth_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH   = 1024,
    parameter int unsigned FRAME_HEIGHT  = 768,
    parameter int unsigned VALUE_BITS    = 9,
    parameter int unsigned KERNEL_WIDTH  = 3,
    parameter int unsigned KERNEL_HEIGHT = 3,
    parameter int unsigned CALC_LATENCY  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            frame_done,
    input  logic                            in_valid,
    input  logic [VALUE_BITS-1:0]           in_data,
    output logic                            in_ready,
    output logic                            win_en,
    output logic [VALUE_BITS-1:0]           win_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FRAME_WIDTH)-1:0]  out_x,
    output logic [$clog2(FRAME_HEIGHT)-1:0] out_y,
    output logic                            out_border
);

    localparam int unsigned N  = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int unsigned L  = calc_latency(FRAME_WIDTH, KERNEL_WIDTH, KERNEL_HEIGHT,
                                              CALC_LATENCY);
    localparam int unsigned CW = $clog2(N + L + 1);
    localparam int unsigned XW = $clog2(FRAME_WIDTH);
    localparam int unsigned YW = $clog2(FRAME_HEIGHT);

    localparam logic [CW-1:0] EN_FIRST = CW'(L);
    localparam logic [CW-1:0] EN_LAST  = CW'(N + L - 1);
    localparam logic [XW-1:0] X_LO     = XW'(KERNEL_WIDTH / 2);
    localparam logic [XW-1:0] X_HI     = XW'(FRAME_WIDTH - KERNEL_WIDTH / 2);
    localparam logic [YW-1:0] Y_LO     = YW'(KERNEL_HEIGHT / 2);
    localparam logic [YW-1:0] Y_HI     = YW'(FRAME_HEIGHT - KERNEL_HEIGHT / 2);

    ctrl_state_e   state_q, state_d;
    logic [CW-1:0] en_cnt_q;
    logic          out_valid_q;
    logic          stall;
    logic          frame_start;
    logic          in_accept;
    logic          in_last;
    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;
    logic          out_last;
    logic          unused_sig;

    assign stall       = out_valid_q && !out_ready;
    assign frame_start = (state_q == StIdle) && start;
    assign in_accept   = (state_q == StRun) && in_valid && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy       = 1'b1;
        frame_done = 1'b0;
        in_ready   = 1'b0;
        win_en     = 1'b0;
        win_data   = '0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) state_d = StRun;
            end
            StRun: begin
                in_ready = !stall;
                win_en   = in_accept;
                win_data = in_data;
                if (in_accept && in_last) state_d = StFlush;
            end
            StFlush: begin
                // Zero padding pushes the last rows through the window.
                win_en = !stall;
                if (!stall && (en_cnt_q == EN_LAST)) state_d = StDone;
            end
            StDone: begin
                frame_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_cnt_q <= '0;
        end else if (frame_start) begin
            en_cnt_q <= '0;
        end else if (win_en) begin
            en_cnt_q <= en_cnt_q + 1'b1;
        end
    end

    // The smoother's result register is live once the window has filled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else if (win_en) begin
            out_valid_q <= (en_cnt_q >= EN_FIRST);
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;

    xy_counter #(
        .WIDTH  (FRAME_WIDTH),
        .HEIGHT (FRAME_HEIGHT)
    ) u_in_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (frame_start),
        .inc  (in_accept),
        .x    (in_x),
        .y    (in_y),
        .last (in_last)
    );

    xy_counter #(
        .WIDTH  (FRAME_WIDTH),
        .HEIGHT (FRAME_HEIGHT)
    ) u_out_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (frame_start),
        .inc  (out_valid_q && out_ready),
        .x    (out_x),
        .y    (out_y),
        .last (out_last)
    );

    assign out_border = (out_x < X_LO) || (out_x >= X_HI) || (out_y < Y_LO) || (out_y >= Y_HI);

    assign unused_sig = ^{in_x, in_y, out_last};

endmodule

// File: tb/tb_smooth_frame_ctrl.sv
// Randomised self-checking bench for smooth_frame_ctrl on an 8x4 frame.
module tb_smooth_frame_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int KW = 3;
    localparam int KH = 3;
    localparam int CL = 2;
    localparam int N  = W * H;
    localparam int L  = W * (KH / 2) + KW / 2 + CL;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       frame_done;
    logic       in_valid;
    logic [8:0] in_data;
    logic       in_ready;
    logic       win_en;
    logic [8:0] win_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_x;
    logic [1:0] out_y;
    logic       out_border;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_phase;  // 0 idle, 1 run, 2 flush, 3 done
    int m_acc;
    int m_en;
    int m_flush;
    int m_idx;
    bit m_ov;

    // Per-frame observation
    int en_seen;
    int xfers;
    int fd_cnt;
    bit seen_ov;

    smooth_frame_ctrl #(
        .FRAME_WIDTH   (W),
        .FRAME_HEIGHT  (H),
        .VALUE_BITS    (9),
        .KERNEL_WIDTH  (KW),
        .KERNEL_HEIGHT (KH),
        .CALC_LATENCY  (CL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .win_en     (win_en),
        .win_data   (win_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_border (out_border)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_acc   = 0;
        m_en    = 0;
        m_flush = 0;
        m_idx   = 0;
        m_ov    = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_win_en", win_en, 0);
        check("rst_win_data", win_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
    endtask

    task automatic cycle(input bit st, input bit iv, input bit ordy);
        bit stall;
        int e_ir, e_we, e_wd, k, ex, ey, eb;
        @(negedge clk);
        start     = st;
        in_valid  = iv;
        in_data   = 9'($urandom);
        out_ready = ordy;
        #1;
        stall = m_ov && !ordy;
        e_ir  = 0;
        e_we  = 0;
        e_wd  = 0;
        if (m_phase == 1) begin
            e_ir = stall ? 0 : 1;
            e_we = (iv && !stall) ? 1 : 0;
            e_wd = int'(in_data);
        end else if (m_phase == 2) begin
            e_we = stall ? 0 : 1;
        end
        k  = m_idx % N;
        ex = k % W;
        ey = k / W;
        eb = (ex < KW / 2 || ex >= W - KW / 2 || ey < KH / 2 || ey >= H - KH / 2) ? 1 : 0;

        check("in_ready", in_ready, e_ir);
        check("win_en", win_en, e_we);
        check("win_data", win_data, e_wd);
        check("out_valid", out_valid, int'(m_ov));
        check("busy", busy, (m_phase != 0) ? 1 : 0);
        check("frame_done", frame_done, (m_phase == 3) ? 1 : 0);
        check("out_x", out_x, ex);
        check("out_y", out_y, ey);
        check("out_border", out_border, eb);

        if (out_valid && !seen_ov) begin
            seen_ov = 1'b1;
            check("first_ov_after_enables", en_seen, L + 1);
        end
        if (win_en) en_seen++;
        if (frame_done) fd_cnt++;
        if (out_valid && ordy) xfers++;

        if (m_ov && ordy) m_idx++;
        if (e_we != 0) begin
            m_ov = (m_en >= L);
            m_en++;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        case (m_phase)
            0: if (st) begin
                m_phase = 1;
                m_acc   = 0;
                m_en    = 0;
                m_flush = 0;
                m_idx   = 0;
            end
            1: if (e_we != 0) begin
                m_acc++;
                if (m_acc == N) m_phase = 2;
            end
            2: if (e_we != 0) begin
                m_flush++;
                if (m_flush == L) m_phase = 3;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic run_frame(input int gap_pct, input int stall_pct, input bit burst,
                             input bit extra_start, input int rst_at);
        bit done;
        bit iv, ordy, st;
        en_seen = 0;
        xfers   = 0;
        fd_cnt  = 0;
        seen_ov = 1'b0;
        done    = 1'b0;
        cycle(1'b1, 1'b1, 1'b1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (m_phase == 0 && !m_ov) begin
                done = 1'b1;
                break;
            end
            if (rst_at > 0 && m_phase == 1 && m_acc == rst_at) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = 9'h1a5;
                #2;
                rst = 1'b1;
                #1;
                check_reset_outputs();
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            iv   = ($urandom_range(99) >= gap_pct);
            ordy = ($urandom_range(99) >= stall_pct);
            if (burst && cyc >= 20 && cyc < 25) ordy = 1'b0;
            st = extra_start && (m_phase == 3 || $urandom_range(3) == 0);
            cycle(st, iv, ordy);
        end
        if (!done) check("frame_timeout", 1, 0);
        check("frame_done_count", fd_cnt, 1);
        check("transfers", xfers, N);
        check("enables", en_seen, N + L);
        check("saw_out_valid", seen_ov, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        run_frame(0, 0, 1'b0, 1'b0, 0);
        run_frame(0, 0, 1'b1, 1'b0, 0);
        run_frame(50, 0, 1'b0, 1'b0, 0);
        run_frame(30, 30, 1'b0, 1'b1, 0);
        run_frame(0, 0, 1'b0, 1'b0, 20);
        run_frame(0, 0, 1'b0, 1'b0, 0);
        run_frame(40, 40, 1'b1, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
